// File: rtl/dpcm_pkg.sv
// Shared definitions for the DPCM decoder and its companion encoder: bus FSM
// states, default sample width and register addresses.
package dpcm_pkg;

  // Default width of samples and differences
  localparam int unsigned DW_DEFAULT = 8;

  // Register map (single address bit)
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  // Bus FSM; encoding 2'b11 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } bus_state_e;

endpackage

// File: rtl/dpcm_sat_add.sv
// Combinational signed saturating adder. Adds at DW+1 bits and clamps the
// result to the DW-bit signed range, flagging when the clamp engaged.
module dpcm_sat_add
  import dpcm_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] y,
  output logic                 clamped
);

  localparam logic signed [DW-1:0] MaxVal = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MinVal = {1'b1, {(DW-1){1'b0}}};

  logic [DW:0] w_sum;

  assign w_sum = {a[DW-1], a} + {b[DW-1], b};

  // Overflow shows as disagreement between the two top bits; the extra top bit
  // carries the true sign and picks which rail to clamp to.
  always_comb begin
    clamped = w_sum[DW] ^ w_sum[DW-1];
    y       = w_sum[DW-1:0];
    if (clamped) begin
      y = w_sum[DW] ? MinVal : MaxVal;
    end
  end

endmodule

// File: rtl/dpcm_decoder.sv
// DPCM decoder behind an APB-style slave port. DATA writes accumulate a signed
// difference onto the predictor with saturation; CTRL writes seed the predictor.
module dpcm_decoder
  import dpcm_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic                 paddr,
  input  logic signed [DW-1:0] pwdata,
  output logic        [DW-1:0] prdata,
  output logic                 pready,
  output logic signed [DW-1:0] sample_out,
  output logic                 sample_valid,
  output logic                 sat_flag,
  output logic        [1:0]    estado
);

  localparam logic [DW-1:0] CntOne = {{(DW-1){1'b0}}, 1'b1};

  bus_state_e          r_state;
  logic signed [DW-1:0] r_pred;
  logic signed [DW-1:0] r_sample_out;
  logic                 r_valid;
  logic                 r_sat;
  logic        [DW-1:0] r_cnt;

  logic                 w_access;
  logic                 w_wr;
  logic                 w_wr_data;
  logic                 w_wr_ctrl;
  logic signed [DW-1:0] w_sum;
  logic                 w_clamped;

  assign w_access  = (r_state == ACCESS);
  assign w_wr      = w_access & psel & penable & pwrite;
  assign w_wr_data = w_wr & (paddr == ADDR_DATA);
  assign w_wr_ctrl = w_wr & (paddr == ADDR_CTRL);

  dpcm_sat_add #(
    .DW(DW)
  ) u_sat_add (
    .a      (r_pred),
    .b      (pwdata),
    .y      (w_sum),
    .clamped(w_clamped)
  );

  // Bus FSM: IDLE -> SETUP -> ACCESS, one transfer completes per ACCESS edge
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= (psel && !penable) ? SETUP : IDLE;
        end
        SETUP: begin
          if (!psel) begin
            r_state <= IDLE;
          end else if (penable) begin
            r_state <= ACCESS;
          end else begin
            r_state <= SETUP;
          end
        end
        ACCESS: begin
          r_state <= (psel && !penable) ? SETUP : IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Datapath: predictor, output sample, pulse, sticky flag and sample counter
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_pred       <= '0;
      r_sample_out <= '0;
      r_valid      <= 1'b0;
      r_sat        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_valid <= w_wr_data;
      if (w_wr_data) begin
        r_pred       <= w_sum;
        r_sample_out <= w_sum;
        r_cnt        <= r_cnt + CntOne;
        // Sticky: only ever sets here; clearing is a CTRL-write side effect
        if (w_clamped) begin
          r_sat <= 1'b1;
        end
      end else if (w_wr_ctrl) begin
        r_pred <= pwdata;
        r_sat  <= 1'b0;
        r_cnt  <= '0;
      end
    end
  end

  // Read mux: live only for reads in ACCESS, zero otherwise
  always_comb begin
    prdata = '0;
    if (w_access && !pwrite) begin
      prdata = (paddr == ADDR_CTRL) ? r_cnt : r_pred;
    end
  end

  assign pready       = w_access;
  assign estado       = r_state;
  assign sample_out   = r_sample_out;
  assign sample_valid = r_valid;
  assign sat_flag     = r_sat;

endmodule

// File: tb/tb_dpcm_decoder.sv
// Directed self-checking bench for dpcm_decoder (DW = 8).
module tb_dpcm_decoder;

  logic              pclk = 1'b0;
  logic              preset;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic              paddr;
  logic signed [7:0] pwdata;
  logic        [7:0] prdata;
  logic              pready;
  logic signed [7:0] sample_out;
  logic              sample_valid;
  logic              sat_flag;
  logic        [1:0] estado;

  int n_tests = 0;
  int n_fail  = 0;
  int rd;

  dpcm_decoder #(
    .DW(8)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .sat_flag    (sat_flag),
    .estado      (estado)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Full write transfer; returns at the falling edge after the commit edge
  task automatic apb_write(input logic a, input int d);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d[7:0];
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Full read transfer; prdata captured mid-ACCESS
  task automatic apb_read(input logic a, output int v);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    v = int'(prdata);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 1'b0; pwdata = '0;
    repeat (2) @(negedge pclk);
    check_eq("rst_estado", estado, 0);
    check_eq("rst_sample", sample_out, 0);
    check_eq("rst_valid", sample_valid, 0);
    check_eq("rst_sat", sat_flag, 0);
    check_eq("rst_pready", pready, 0);
    check_eq("rst_prdata", prdata, 0);
    preset = 1'b0;

    // Plain accumulation
    apb_write(1'b0, 10);
    check_eq("d10_sample", sample_out, 10);
    check_eq("d10_valid", sample_valid, 1);
    @(negedge pclk);
    check_eq("d10_valid_drop", sample_valid, 0);
    apb_write(1'b0, 20);
    check_eq("d20_sample", sample_out, 30);
    check_eq("d20_valid", sample_valid, 1);
    apb_write(1'b0, -5);
    check_eq("dm5_sample", sample_out, 25);
    check_eq("dm5_valid", sample_valid, 1);
    check_eq("dm5_sat", sat_flag, 0);
    apb_read(1'b1, rd);
    check_eq("cnt_3", rd, 3);
    apb_read(1'b0, rd);
    check_eq("pred_25", rd, 25);
    check_eq("prdata_idle", prdata, 0);

    // Positive saturation, sticky flag
    apb_write(1'b1, 120);
    check_eq("ctrl120_sample_kept", sample_out, 25);
    check_eq("ctrl120_no_valid", sample_valid, 0);
    apb_write(1'b0, 20);
    check_eq("pos_sat_sample", sample_out, 127);
    check_eq("pos_sat_flag", sat_flag, 1);
    apb_write(1'b0, -10);
    check_eq("after_sat_sample", sample_out, 117);
    check_eq("sat_sticky", sat_flag, 1);
    apb_read(1'b0, rd);
    check_eq("pred_117", rd, 117);

    // Negative saturation, then clear via CTRL
    apb_write(1'b1, -100);
    check_eq("ctrl_clears_sat", sat_flag, 0);
    apb_write(1'b0, -100);
    check_eq("neg_sat_sample", sample_out, -128);
    check_eq("neg_sat_flag", sat_flag, 1);
    apb_read(1'b1, rd);
    check_eq("cnt_1", rd, 1);
    apb_write(1'b1, 0);
    check_eq("ctrl0_sat", sat_flag, 0);
    apb_read(1'b1, rd);
    check_eq("ctrl0_cnt", rd, 0);

    // Back-to-back writes with psel held. penable is still high on the
    // completing edge, so the FSM passes IDLE for one cycle before SETUP.
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 1'b0; pwdata = 8'sd5;
    @(negedge pclk);
    check_eq("b2b_setup1", estado, 1);
    check_eq("b2b_pready_setup1", pready, 0);
    penable = 1'b1;
    @(negedge pclk);
    check_eq("b2b_access1", estado, 2);
    check_eq("b2b_pready_access1", pready, 1);
    @(negedge pclk);
    check_eq("b2b_sample1", sample_out, 5);
    check_eq("b2b_valid1", sample_valid, 1);
    check_eq("b2b_pready_gap", pready, 0);
    penable = 1'b0; pwdata = 8'sd7;
    @(negedge pclk);
    check_eq("b2b_setup2", estado, 1);
    check_eq("b2b_pready_setup2", pready, 0);
    penable = 1'b1;
    @(negedge pclk);
    check_eq("b2b_access2", estado, 2);
    check_eq("b2b_pready_access2", pready, 1);
    @(negedge pclk);
    check_eq("b2b_sample2", sample_out, 12);
    check_eq("b2b_valid2", sample_valid, 1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;

    // Abort from SETUP leaves state alone
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 1'b0; pwdata = 8'sd99;
    @(negedge pclk);
    check_eq("abort_setup", estado, 1);
    psel = 1'b0; pwrite = 1'b0;
    @(negedge pclk);
    check_eq("abort_idle", estado, 0);
    check_eq("abort_no_valid", sample_valid, 0);
    apb_read(1'b0, rd);
    check_eq("abort_pred", rd, 12);

    // Reset during ACCESS of a write
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 1'b0; pwdata = 8'sd50;
    @(negedge pclk);
    penable = 1'b1;
    @(posedge pclk);
    #2 preset = 1'b1;
    #1;
    check_eq("rstmid_estado", estado, 0);
    check_eq("rstmid_sample", sample_out, 0);
    check_eq("rstmid_valid", sample_valid, 0);
    check_eq("rstmid_sat", sat_flag, 0);
    check_eq("rstmid_pready", pready, 0);
    check_eq("rstmid_prdata", prdata, 0);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
    check_eq("rstmid_idle_after", estado, 0);
    apb_read(1'b0, rd);
    check_eq("rstmid_pred", rd, 0);
    apb_read(1'b1, rd);
    check_eq("rstmid_cnt", rd, 0);

    // Counter wrap
    apb_write(1'b1, 33);
    for (int i = 0; i < 255; i++) begin
      apb_write(1'b0, 0);
    end
    apb_read(1'b1, rd);
    check_eq("cnt_255", rd, 255);
    apb_write(1'b0, 0);
    apb_read(1'b1, rd);
    check_eq("cnt_wrap", rd, 0);
    apb_read(1'b0, rd);
    check_eq("wrap_pred", rd, 33);
    check_eq("wrap_sample", sample_out, 33);
    check_eq("wrap_sat", sat_flag, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
